// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - 2-wide in-order retirement buffer returning superseded physical registers
module reorder_buffer #(
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 4,
    parameter int PREG_W = 6,
    parameter int AREG_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc_valid_1,
    input  logic              alloc_valid_2,
    input  logic              alloc_wen_1,
    input  logic              alloc_wen_2,
    input  logic [AREG_W-1:0] alloc_rd_1,
    input  logic [AREG_W-1:0] alloc_rd_2,
    input  logic [PREG_W-1:0] alloc_newrd_1,
    input  logic [PREG_W-1:0] alloc_newrd_2,
    input  logic [PREG_W-1:0] alloc_oldrd_1,
    input  logic [PREG_W-1:0] alloc_oldrd_2,
    output logic              alloc_ready,
    output logic [IDX_W-1:0]  alloc_idx_1,
    output logic [IDX_W-1:0]  alloc_idx_2,
    input  logic              cmpl_valid_1,
    input  logic              cmpl_valid_2,
    input  logic              cmpl_valid_3,
    input  logic [IDX_W-1:0]  cmpl_idx_1,
    input  logic [IDX_W-1:0]  cmpl_idx_2,
    input  logic [IDX_W-1:0]  cmpl_idx_3,
    output logic              retire_valid_1,
    output logic              retire_valid_2,
    output logic [AREG_W-1:0] retire_rd_1,
    output logic [AREG_W-1:0] retire_rd_2,
    output logic [PREG_W-1:0] retire_prd_1,
    output logic [PREG_W-1:0] retire_prd_2,
    output logic              free_valid_1,
    output logic              free_valid_2,
    output logic [PREG_W-1:0] free_preg_1,
    output logic [PREG_W-1:0] free_preg_2,
    output logic [IDX_W:0]    count,
    output logic              empty
);

    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  done_q;
    logic [DEPTH-1:0]  wen_q;
    logic [AREG_W-1:0] rd_q    [DEPTH];
    logic [PREG_W-1:0] newrd_q [DEPTH];
    logic [PREG_W-1:0] oldrd_q [DEPTH];

    logic [IDX_W-1:0]  head_q;
    logic [IDX_W-1:0]  tail_q;
    logic [IDX_W:0]    count_q;

    logic [IDX_W-1:0]  head_p1;
    logic [IDX_W-1:0]  tail_p1;
    logic              do_alloc_1;
    logic              do_alloc_2;
    logic [1:0]        n_alloc;
    logic [1:0]        n_retire;
    logic              r1;
    logic              r2;
    logic [2:0]        cmpl_valid;
    logic [IDX_W-1:0]  cmpl_idx [3];

    always_comb begin
        head_p1     = head_q + 1'b1;
        tail_p1     = tail_q + 1'b1;
        alloc_ready = (count_q <= (IDX_W+1)'(DEPTH - 2));
        do_alloc_1  = alloc_ready & alloc_valid_1;
        do_alloc_2  = alloc_ready & alloc_valid_2;
        alloc_idx_1 = tail_q;
        // A lone slot-2 instruction takes the tail just like a lone slot-1 one.
        alloc_idx_2 = (alloc_valid_1 & alloc_valid_2) ? tail_p1 : tail_q;
        n_alloc     = {1'b0, do_alloc_1} + {1'b0, do_alloc_2};
        r1          = valid_q[head_q] & done_q[head_q];
        r2          = r1 & valid_q[head_p1] & done_q[head_p1];
        n_retire    = {1'b0, r1} + {1'b0, r2};
        count       = count_q;
        empty       = (count_q == '0);
        cmpl_valid  = {cmpl_valid_3, cmpl_valid_2, cmpl_valid_1};
        cmpl_idx[0] = cmpl_idx_1;
        cmpl_idx[1] = cmpl_idx_2;
        cmpl_idx[2] = cmpl_idx_3;
    end

    // Control state: completion is applied before retire/alloc so that a
    // same-edge retire or reallocation of that slot leaves done cleared.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            done_q  <= '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (cmpl_valid[k] && valid_q[cmpl_idx[k]]) begin
                    done_q[cmpl_idx[k]] <= 1'b1;
                end
            end
            if (r1) begin
                valid_q[head_q] <= 1'b0;
                done_q[head_q]  <= 1'b0;
            end
            if (r2) begin
                valid_q[head_p1] <= 1'b0;
                done_q[head_p1]  <= 1'b0;
            end
            if (do_alloc_1) begin
                valid_q[alloc_idx_1] <= 1'b1;
                done_q[alloc_idx_1]  <= 1'b0;
            end
            if (do_alloc_2) begin
                valid_q[alloc_idx_2] <= 1'b1;
                done_q[alloc_idx_2]  <= 1'b0;
            end
            head_q  <= head_q + IDX_W'(n_retire);
            tail_q  <= tail_q + IDX_W'(n_alloc);
            count_q <= count_q + (IDX_W+1)'(n_alloc) - (IDX_W+1)'(n_retire);
        end
    end

    // Payload fields are only meaningful while valid, so they carry no reset.
    always_ff @(posedge clk) begin
        if (do_alloc_1 && !reset) begin
            wen_q[alloc_idx_1]   <= alloc_wen_1;
            rd_q[alloc_idx_1]    <= alloc_rd_1;
            newrd_q[alloc_idx_1] <= alloc_newrd_1;
            oldrd_q[alloc_idx_1] <= alloc_oldrd_1;
        end
        if (do_alloc_2 && !reset) begin
            wen_q[alloc_idx_2]   <= alloc_wen_2;
            rd_q[alloc_idx_2]    <= alloc_rd_2;
            newrd_q[alloc_idx_2] <= alloc_newrd_2;
            oldrd_q[alloc_idx_2] <= alloc_oldrd_2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            retire_valid_1 <= 1'b0;
            retire_valid_2 <= 1'b0;
            retire_rd_1    <= '0;
            retire_rd_2    <= '0;
            retire_prd_1   <= '0;
            retire_prd_2   <= '0;
            free_valid_1   <= 1'b0;
            free_valid_2   <= 1'b0;
            free_preg_1    <= '0;
            free_preg_2    <= '0;
        end else begin
            retire_valid_1 <= r1;
            retire_valid_2 <= r2;
            retire_rd_1    <= r1 ? rd_q[head_q]     : '0;
            retire_rd_2    <= r2 ? rd_q[head_p1]    : '0;
            retire_prd_1   <= r1 ? newrd_q[head_q]  : '0;
            retire_prd_2   <= r2 ? newrd_q[head_p1] : '0;
            free_valid_1   <= r1 & wen_q[head_q];
            free_valid_2   <= r2 & wen_q[head_p1];
            free_preg_1    <= r1 ? oldrd_q[head_q]  : '0;
            free_preg_2    <= r2 ? oldrd_q[head_p1] : '0;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - table, directed and randomized checks of reorder_buffer against a queue model
module tb_reorder_buffer;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       alloc_valid_1, alloc_valid_2, alloc_wen_1, alloc_wen_2;
    logic [4:0] alloc_rd_1, alloc_rd_2;
    logic [5:0] alloc_newrd_1, alloc_newrd_2, alloc_oldrd_1, alloc_oldrd_2;
    logic       alloc_ready;
    logic [3:0] alloc_idx_1, alloc_idx_2;
    logic       cmpl_valid_1, cmpl_valid_2, cmpl_valid_3;
    logic [3:0] cmpl_idx_1, cmpl_idx_2, cmpl_idx_3;
    logic       retire_valid_1, retire_valid_2;
    logic [4:0] retire_rd_1, retire_rd_2;
    logic [5:0] retire_prd_1, retire_prd_2;
    logic       free_valid_1, free_valid_2;
    logic [5:0] free_preg_1, free_preg_2;
    logic [4:0] count;
    logic       empty;

    always #5 clk = ~clk;

    reorder_buffer dut (
        .clk(clk), .reset(reset),
        .alloc_valid_1(alloc_valid_1), .alloc_valid_2(alloc_valid_2),
        .alloc_wen_1(alloc_wen_1), .alloc_wen_2(alloc_wen_2),
        .alloc_rd_1(alloc_rd_1), .alloc_rd_2(alloc_rd_2),
        .alloc_newrd_1(alloc_newrd_1), .alloc_newrd_2(alloc_newrd_2),
        .alloc_oldrd_1(alloc_oldrd_1), .alloc_oldrd_2(alloc_oldrd_2),
        .alloc_ready(alloc_ready), .alloc_idx_1(alloc_idx_1), .alloc_idx_2(alloc_idx_2),
        .cmpl_valid_1(cmpl_valid_1), .cmpl_valid_2(cmpl_valid_2), .cmpl_valid_3(cmpl_valid_3),
        .cmpl_idx_1(cmpl_idx_1), .cmpl_idx_2(cmpl_idx_2), .cmpl_idx_3(cmpl_idx_3),
        .retire_valid_1(retire_valid_1), .retire_valid_2(retire_valid_2),
        .retire_rd_1(retire_rd_1), .retire_rd_2(retire_rd_2),
        .retire_prd_1(retire_prd_1), .retire_prd_2(retire_prd_2),
        .free_valid_1(free_valid_1), .free_valid_2(free_valid_2),
        .free_preg_1(free_preg_1), .free_preg_2(free_preg_2),
        .count(count), .empty(empty)
    );

    typedef struct packed {
        logic       v1, v2, w1, w2;
        logic [4:0] rd1, rd2;
        logic [5:0] nr1, nr2, or1, or2;
        logic       c1, c2, c3;
        logic [3:0] i1, i2, i3;
    } stim_t;

    typedef struct {
        stim_t      s;
        logic [3:0] e_i1, e_i2;
        int         e_cnt;
        logic       e_rv1, e_rv2;
        logic [5:0] e_prd1, e_prd2, e_fp1, e_fp2;
    } vec_t;

    typedef struct {
        int         idx;
        logic       wen;
        logic [4:0] rd;
        logic [5:0] nr, orr;
        bit         done;
    } ent_t;

    ent_t       q[$];
    int         m_tail;
    logic       e_rv[2], e_fv[2], e_wen[2];
    logic [4:0] e_rd[2];
    logic [5:0] e_prd[2], e_fp[2];

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic stim_t sa(bit v1, bit v2, bit w1, bit w2, int rd1, int rd2,
                                 int nr1, int nr2, int or1, int or2);
        stim_t s = '0;
        s.v1 = v1; s.v2 = v2; s.w1 = w1; s.w2 = w2;
        s.rd1 = 5'(rd1); s.rd2 = 5'(rd2);
        s.nr1 = 6'(nr1); s.nr2 = 6'(nr2); s.or1 = 6'(or1); s.or2 = 6'(or2);
        return s;
    endfunction

    function automatic stim_t sc(bit c1, int i1, bit c2, int i2, bit c3, int i3);
        stim_t s = '0;
        s.c1 = c1; s.i1 = 4'(i1); s.c2 = c2; s.i2 = 4'(i2); s.c3 = c3; s.i3 = 4'(i3);
        return s;
    endfunction

    // Program-order queue model: the head of the queue is the oldest instruction.
    task automatic model_edge(input logic rst, input stim_t s);
        int n;
        bit rdy;
        ent_t e;
        for (int i = 0; i < 2; i++) begin
            e_rv[i] = 0; e_fv[i] = 0; e_wen[i] = 0; e_rd[i] = 0; e_prd[i] = 0; e_fp[i] = 0;
        end
        if (rst) begin
            q.delete();
            m_tail = 0;
            return;
        end
        n = 0;
        if (q.size() > 0 && q[0].done) n = 1;
        if (n == 1 && q.size() > 1 && q[1].done) n = 2;
        for (int i = 0; i < n; i++) begin
            e_rv[i] = 1; e_rd[i] = q[i].rd; e_prd[i] = q[i].nr;
            e_fv[i] = q[i].wen; e_wen[i] = q[i].wen; e_fp[i] = q[i].orr;
        end
        rdy = (q.size() <= DEPTH - 2);
        for (int i = 0; i < q.size(); i++) begin
            if ((s.c1 && int'(s.i1) == q[i].idx) || (s.c2 && int'(s.i2) == q[i].idx) ||
                (s.c3 && int'(s.i3) == q[i].idx)) q[i].done = 1;
        end
        repeat (n) void'(q.pop_front());
        if (rdy && s.v1) begin
            e.idx = m_tail; e.wen = s.w1; e.rd = s.rd1; e.nr = s.nr1; e.orr = s.or1; e.done = 0;
            q.push_back(e);
            m_tail = (m_tail + 1) % DEPTH;
        end
        if (rdy && s.v2) begin
            e.idx = m_tail; e.wen = s.w2; e.rd = s.rd2; e.nr = s.nr2; e.orr = s.or2; e.done = 0;
            q.push_back(e);
            m_tail = (m_tail + 1) % DEPTH;
        end
    endtask

    task automatic cycle(input logic rst, input stim_t s,
                         output logic [3:0] pi1, output logic [3:0] pi2, output logic prdy);
        logic       a_rv[2], a_fv[2];
        logic [4:0] a_rd[2];
        logic [5:0] a_prd[2], a_fp[2];
        reset = rst;
        alloc_valid_1 = s.v1; alloc_valid_2 = s.v2; alloc_wen_1 = s.w1; alloc_wen_2 = s.w2;
        alloc_rd_1 = s.rd1; alloc_rd_2 = s.rd2; alloc_newrd_1 = s.nr1; alloc_newrd_2 = s.nr2;
        alloc_oldrd_1 = s.or1; alloc_oldrd_2 = s.or2;
        cmpl_valid_1 = s.c1; cmpl_valid_2 = s.c2; cmpl_valid_3 = s.c3;
        cmpl_idx_1 = s.i1; cmpl_idx_2 = s.i2; cmpl_idx_3 = s.i3;
        #1;
        pi1 = alloc_idx_1; pi2 = alloc_idx_2; prdy = alloc_ready;
        chk("alloc_ready", 32'(alloc_ready), 32'(q.size() <= DEPTH - 2));
        chk("alloc_idx_1", 32'(alloc_idx_1), 32'(m_tail));
        chk("alloc_idx_2", 32'(alloc_idx_2), 32'((s.v1 && s.v2) ? (m_tail + 1) % DEPTH : m_tail));
        model_edge(rst, s);
        @(posedge clk);
        #1;
        a_rv[0] = retire_valid_1; a_rv[1] = retire_valid_2;
        a_fv[0] = free_valid_1;   a_fv[1] = free_valid_2;
        a_rd[0] = retire_rd_1;    a_rd[1] = retire_rd_2;
        a_prd[0] = retire_prd_1;  a_prd[1] = retire_prd_2;
        a_fp[0] = free_preg_1;    a_fp[1] = free_preg_2;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("retire_valid_%0d", i + 1), 32'(a_rv[i]), 32'(e_rv[i]));
            chk($sformatf("retire_rd_%0d", i + 1), 32'(a_rd[i]), 32'(e_rd[i]));
            chk($sformatf("retire_prd_%0d", i + 1), 32'(a_prd[i]), 32'(e_prd[i]));
            chk($sformatf("free_valid_%0d", i + 1), 32'(a_fv[i]), 32'(e_fv[i]));
            if (!(e_rv[i] && !e_wen[i]))
                chk($sformatf("free_preg_%0d", i + 1), 32'(a_fp[i]), 32'(e_fp[i]));
        end
        chk("count", 32'(count), 32'(q.size()));
        chk("empty", 32'(empty), 32'(q.size() == 0));
    endtask

    task automatic go(input logic rst, input stim_t s);
        logic [3:0] a, b;
        logic r;
        cycle(rst, s, a, b, r);
    endtask

    task automatic idle(input int n);
        repeat (n) go(1'b0, '0);
    endtask

    vec_t       tv[6];
    stim_t      s;
    logic [3:0] pi1, pi2;
    logic       prdy;
    int         pk;

    initial begin
        m_tail = 0;
        reset = 1'b1;
        go(1'b1, '0);
        go(1'b1, '0);
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_ready", 32'(alloc_ready), 32'd1);
        chk("reset_retire", 32'({retire_valid_1, retire_valid_2, free_valid_1, free_valid_2}), 32'd0);

        // Pair allocate, out-of-order completion, then joint retirement.
        tv[0] = '{sa(1,1,1,1,3,4,40,41,3,4), 4'd0, 4'd1, 2, 0, 0, 6'd0, 6'd0, 6'd0, 6'd0};
        tv[1] = '{sc(1,1,0,0,0,0),           4'd2, 4'd2, 2, 0, 0, 6'd0, 6'd0, 6'd0, 6'd0};
        tv[2] = '{'0,                        4'd2, 4'd2, 2, 0, 0, 6'd0, 6'd0, 6'd0, 6'd0};
        tv[3] = '{sc(0,0,1,0,0,0),           4'd2, 4'd2, 2, 0, 0, 6'd0, 6'd0, 6'd0, 6'd0};
        tv[4] = '{'0,                        4'd2, 4'd2, 0, 1, 1, 6'd40, 6'd41, 6'd3, 6'd4};
        tv[5] = '{'0,                        4'd2, 4'd2, 0, 0, 0, 6'd0, 6'd0, 6'd0, 6'd0};
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, tv[i].s, pi1, pi2, prdy);
            chk($sformatf("tv%0d_idx1", i), 32'(pi1), 32'(tv[i].e_i1));
            chk($sformatf("tv%0d_idx2", i), 32'(pi2), 32'(tv[i].e_i2));
            chk($sformatf("tv%0d_count", i), 32'(count), 32'(tv[i].e_cnt));
            chk($sformatf("tv%0d_empty", i), 32'(empty), 32'(tv[i].e_cnt == 0));
            chk($sformatf("tv%0d_rv", i), 32'({retire_valid_1, retire_valid_2}), 32'({tv[i].e_rv1, tv[i].e_rv2}));
            if (tv[i].e_rv1) begin
                chk($sformatf("tv%0d_prd", i), 32'({retire_prd_1, retire_prd_2}), 32'({tv[i].e_prd1, tv[i].e_prd2}));
                chk($sformatf("tv%0d_fp", i), 32'({free_preg_1, free_preg_2}), 32'({tv[i].e_fp1, tv[i].e_fp2}));
            end
        end

        // Fill to full; allocation is refused once fewer than two slots remain.
        go(1'b1, '0);
        for (int i = 0; i < 7; i++) go(1'b0, sa(1,1,1,1,i,i+1,i,i+1,i,i+1));
        chk("fill14_count", 32'(count), 32'd14);
        chk("fill14_ready", 32'(alloc_ready), 32'd1);
        go(1'b0, sa(1,1,1,1,9,9,9,9,9,9));
        chk("fill16_count", 32'(count), 32'd16);
        chk("fill16_ready", 32'(alloc_ready), 32'd0);
        cycle(1'b0, sa(1,1,1,1,8,8,8,8,8,8), pi1, pi2, prdy);
        chk("full_tail", 32'(pi1), 32'd0);
        chk("full_count", 32'(count), 32'd16);

        // Store plus add: only the writing instruction frees a register.
        go(1'b1, '0);
        go(1'b0, sa(1,1,0,1,0,7,10,11,20,21));
        go(1'b0, sc(1,0,1,1,0,0));
        go(1'b0, '0);
        chk("st_rv", 32'({retire_valid_1, retire_valid_2}), 32'b11);
        chk("st_fv", 32'({free_valid_1, free_valid_2}), 32'b01);
        chk("st_fp2", 32'(free_preg_2), 32'd21);

        // Walk the pointers to 15, then a pair straddling the wrap.
        go(1'b1, '0);
        for (int i = 0; i < 7; i++) go(1'b0, sa(1,1,1,1,i,i,i+16,i+17,i,i));
        go(1'b0, sa(1,0,1,0,1,0,30,0,5,0));
        for (int c = 0; c < 5; c++) go(1'b0, sc(1,3*c,1,3*c+1,1,3*c+2));
        idle(10);
        chk("wrap_empty", 32'(count), 32'd0);
        cycle(1'b0, sa(1,1,1,1,11,12,50,51,13,14), pi1, pi2, prdy);
        chk("wrap_idx", 32'({pi1, pi2}), 32'({4'd15, 4'd0}));
        go(1'b0, sc(0,0,1,15,1,0));
        go(1'b0, '0);
        chk("wrap_rv", 32'({retire_valid_1, retire_valid_2}), 32'b11);
        chk("wrap_prd", 32'({retire_prd_1, retire_prd_2}), 32'({6'd50, 6'd51}));
        cycle(1'b0, '0, pi1, pi2, prdy);
        chk("wrap_head", 32'(pi1), 32'd1);

        // Alloc and retire in one edge; duplicate completion retires once.
        go(1'b1, '0);
        go(1'b0, sa(1,1,1,1,1,2,1,2,1,2));
        go(1'b0, sa(1,1,1,1,3,4,3,4,3,4));
        go(1'b0, sc(1,0,0,0,0,0));
        go(1'b0, sa(1,1,1,1,5,6,5,6,5,6));
        chk("mix_count", 32'(count), 32'd5);
        chk("mix_rv", 32'({retire_valid_1, retire_valid_2}), 32'b10);
        go(1'b0, sc(1,1,0,0,1,1));
        go(1'b0, '0);
        chk("dup_rv", 32'({retire_valid_1, retire_valid_2}), 32'b10);
        chk("dup_rd", 32'(retire_rd_1), 32'd2);
        go(1'b0, '0);
        chk("dup_once", 32'({retire_valid_1, retire_valid_2}), 32'b00);
        chk("dup_count", 32'(count), 32'd4);

        // Reset discards in-flight entries, including completed ones.
        go(1'b1, '0);
        for (int i = 0; i < 3; i++) go(1'b0, sa(1,1,1,1,i,i,i,i,i,i));
        go(1'b0, sc(1,1,1,2,1,3));
        go(1'b0, '0);
        s = sa(1,1,1,1,7,7,7,7,7,7);
        s.c1 = 1'b1;
        s.i1 = 4'd0;
        go(1'b1, s);
        chk("rst_count", 32'(count), 32'd0);
        for (int i = 0; i < 4; i++) begin
            go(1'b0, '0);
            chk("rst_noretire", 32'({retire_valid_1, retire_valid_2}), 32'b00);
        end

        // Randomized traffic against the queue model.
        go(1'b1, '0);
        for (int n = 0; n < 600; n++) begin
            s = '0;
            s.v1 = ($urandom_range(0, 9) < 6);
            s.v2 = ($urandom_range(0, 9) < 6);
            s.w1 = $urandom_range(0, 1); s.w2 = $urandom_range(0, 1);
            s.rd1 = 5'($urandom); s.rd2 = 5'($urandom);
            s.nr1 = 6'($urandom); s.nr2 = 6'($urandom);
            s.or1 = 6'($urandom); s.or2 = 6'($urandom);
            s.c1 = $urandom_range(0, 1); s.c2 = $urandom_range(0, 1); s.c3 = $urandom_range(0, 1);
            s.i1 = 4'($urandom); s.i2 = 4'($urandom); s.i3 = 4'($urandom);
            if (q.size() > 0 && $urandom_range(0, 9) < 8) begin
                pk = $urandom_range(0, q.size() - 1); s.i1 = 4'(q[pk].idx);
                pk = $urandom_range(0, q.size() - 1); s.i2 = 4'(q[pk].idx);
                pk = $urandom_range(0, q.size() - 1); s.i3 = 4'(q[pk].idx);
            end
            go($urandom_range(0, 149) == 0, s);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
